cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 129 ++++++++++++
 tb/tb_cache_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - cache lookup/refill sequencing FSM with registered Moore outputs
// Optional saturating hit/miss statistics are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dataFinish,
  input  logic             readyCache,
  input  logic             readyMem,
  input  logic             find,
  input  logic             need,
  input  logic             writed,
  output logic             readerEn,
  output logic             adrEn,
  output logic             startCache,
  output logic             startMem,
  output logic             forc,
  output logic             We,
  output logic             MemSel,
  output logic             outputEn,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] hitCnt,
  output logic [CNT_W-1:0] missCnt
);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_CHECK, S_ADR, S_LOOKUP, S_CWAIT, S_HIT,
    S_MISS, S_MWAIT, S_FILL, S_FWAIT, S_MOUT, S_DONE, S_ERR
  } state_t;

  state_t        state, nxt;
  logic [WW-1:0] wcnt;
  logic          wait_last;
  logic          miss_seen;

  assign wait_last = (wcnt == WW'(WAIT_MAX - 1));
  // A response with find=0 is a miss; need only confirms it.
  assign miss_seen = need | ~find;

  // Bit order: readerEn adrEn startCache startMem forc We MemSel outputEn busy done timeout
  function automatic logic [10:0] decode(input state_t s);
    case (s)
      S_READ:   return 11'b10000000100;
      S_CHECK:  return 11'b00000000100;
      S_ADR:    return 11'b01000000100;
      S_LOOKUP: return 11'b00100000100;
      S_CWAIT:  return 11'b00000000100;
      S_HIT:    return 11'b00000001100;
      S_MISS:   return 11'b00011000100;
      S_MWAIT:  return 11'b00001000100;
      S_FILL:   return 11'b00101100100;
      S_FWAIT:  return 11'b00001100100;
      S_MOUT:   return 11'b00000011100;
      S_DONE:   return 11'b00000000010;
      S_ERR:    return 11'b00000000101;
      default:  return 11'b00000000000;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_READ;
      S_READ:   nxt = S_CHECK;
      S_CHECK:  nxt = dataFinish ? S_DONE : S_ADR;
      S_ADR:    nxt = S_LOOKUP;
      S_LOOKUP: nxt = S_CWAIT;
      S_CWAIT: begin
        if (readyCache && find)           nxt = S_HIT;
        else if (readyCache && miss_seen) nxt = S_MISS;
        else if (wait_last)               nxt = S_ERR;
      end
      S_HIT:    nxt = S_READ;
      S_MISS:   nxt = S_MWAIT;
      S_MWAIT: begin
        if (readyMem)       nxt = S_FILL;
        else if (wait_last) nxt = S_ERR;
      end
      S_FILL:   nxt = S_FWAIT;
      S_FWAIT: begin
        if (writed)         nxt = S_MOUT;
        else if (wait_last) nxt = S_ERR;
      end
      S_MOUT:   nxt = S_READ;
      S_DONE:   if (!start) nxt = S_IDLE;
      S_ERR:    if (!start) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
      {readerEn, adrEn, startCache, startMem, forc, We, MemSel, outputEn, busy, done, timeout} <= '0;
    end else begin
      state <= nxt;
      wcnt  <= (nxt == state) ? wcnt + 1'b1 : '0;
      {readerEn, adrEn, startCache, startMem, forc, We, MemSel, outputEn, busy, done, timeout} <= decode(nxt);
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt  <= '0;
      missCnt <= '0;
    end else if (state == S_IDLE && start) begin
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      if (state == S_CWAIT && nxt == S_HIT && hitCnt != '1)   hitCnt  <= hitCnt + 1'b1;
      if (state == S_CWAIT && nxt == S_MISS && missCnt != '1) missCnt <= missCnt + 1'b1;
    end
  end
`else
  assign hitCnt  = '0;
  assign missCnt = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized scenario bench for cache_controller with per-cycle trace checking
// Expected statistics follow CACHE_CTRL_STATS_EN when it is defined for the build.
module tb_cache_controller;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 2;
  localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef CACHE_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  // Expected control vectors: readerEn adrEn startCache startMem forc We MemSel outputEn busy done timeout
  localparam logic [10:0] P_IDLE   = 11'b00000000000;
  localparam logic [10:0] P_READ   = 11'b10000000100;
  localparam logic [10:0] P_CHECK  = 11'b00000000100;
  localparam logic [10:0] P_ADR    = 11'b01000000100;
  localparam logic [10:0] P_LOOKUP = 11'b00100000100;
  localparam logic [10:0] P_CWAIT  = 11'b00000000100;
  localparam logic [10:0] P_HIT    = 11'b00000001100;
  localparam logic [10:0] P_MISS   = 11'b00011000100;
  localparam logic [10:0] P_MWAIT  = 11'b00001000100;
  localparam logic [10:0] P_FILL   = 11'b00101100100;
  localparam logic [10:0] P_FWAIT  = 11'b00001100100;
  localparam logic [10:0] P_MOUT   = 11'b00000011100;
  localparam logic [10:0] P_DONE   = 11'b00000000010;
  localparam logic [10:0] P_ERR    = 11'b00000000101;

  localparam int B_RE = 10, B_ADR = 9, B_SC = 8, B_SM = 7, B_FORC = 6, B_WE = 5;
  localparam int B_MS = 4, B_OE = 3, B_BUSY = 2, B_DONE = 1, B_TO = 0;

  // Input order: start dataFinish readyCache readyMem find need writed
  localparam logic [6:0] M_START = 7'b1000000, M_FIN  = 7'b0100000, M_RC   = 7'b0010000;
  localparam logic [6:0] M_RM    = 7'b0001000, M_FIND = 7'b0000100, M_WR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, dataFinish = 1'b0, readyCache = 1'b0, readyMem = 1'b0;
  logic find = 1'b0, need = 1'b0, writed = 1'b0;
  logic readerEn, adrEn, startCache, startMem, forc, We, MemSel, outputEn, busy, done, timeout;
  logic [CNT_W-1:0] hitCnt, missCnt;
  logic [10:0] dut_v;

  always #5 clk = ~clk;

  cache_controller #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataFinish(dataFinish),
    .readyCache(readyCache), .readyMem(readyMem), .find(find), .need(need), .writed(writed),
    .readerEn(readerEn), .adrEn(adrEn), .startCache(startCache), .startMem(startMem),
    .forc(forc), .We(We), .MemSel(MemSel), .outputEn(outputEn), .busy(busy), .done(done),
    .timeout(timeout), .hitCnt(hitCnt), .missCnt(missCnt)
  );

  assign dut_v = {readerEn, adrEn, startCache, startMem, forc, We, MemSel, outputEn, busy, done, timeout};

  typedef struct {
    logic [10:0] ctl;
    int          hc;
    int          mc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  logic [10:0] trace[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hits     = 0;
  int          misses   = 0;

  function automatic int cnt_exp(input int n);
    return STATS * ((n > CMAX) ? CMAX : n);
  endfunction

  function automatic int first_idx(input int b);
    foreach (trace[i]) if (trace[i][b]) return i + 1;
    return 0;
  endfunction

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (trace[i]) if (trace[i][b]) n++;
    return n;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      n_checks++;
      if (dut_v !== e_cur.ctl || int'(hitCnt) != e_cur.hc || int'(missCnt) != e_cur.mc) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: ctl=%b hit=%0d miss=%0d, expected ctl=%b hit=%0d miss=%0d",
                 $time, dut_v, hitCnt, missCnt, e_cur.ctl, e_cur.hc, e_cur.mc);
      end
    end
  end

  // Inputs outside mask are random noise the controller must ignore in that state.
  task automatic step(input logic [6:0] val, input logic [6:0] mask, input logic [10:0] ctl);
    logic [6:0] r;
    exp_t e;
    r = 7'($urandom);
    r = (r & ~mask) | (val & mask);
    {start, dataFinish, readyCache, readyMem, find, need, writed} = r;
    @(posedge clk);
    e.ctl = ctl;
    e.hc  = cnt_exp(hits);
    e.mc  = cnt_exp(misses);
    exp_q.push_back(e);
    #1 trace.push_back(dut_v);
  endtask

  // Response after d quiet cycles; d >= WAIT_MAX means it never comes.
  task automatic wait_state(input logic [6:0] go_val, input logic [6:0] go_mask, input logic [6:0] wait_mask,
                            input int d, input logic [10:0] stay, input logic [10:0] go,
                            input int kind, output bit err);
    bit fin;
    fin = 0;
    err = 0;
    for (int i = 0; i < WAIT_MAX && !fin; i++) begin
      if (i == d) begin
        if (kind == 1) hits++;
        if (kind == 2) misses++;
        step(go_val, go_mask, go);
        fin = 1;
      end else if (i == WAIT_MAX - 1) begin
        step(7'b0, wait_mask, P_ERR);
        err = 1;
        fin = 1;
      end else begin
        step(7'b0, wait_mask, stay);
      end
    end
  endtask

  task automatic begin_session();
    hits = 0;
    misses = 0;
    step(M_START, M_START, P_READ);
  endtask

  task automatic do_addr(input bit hit, input int dc, input int dm, input int dw, output bit err);
    step(7'b0, 7'b0, P_CHECK);
    step(7'b0, M_FIN, P_ADR);
    step(7'b0, 7'b0, P_LOOKUP);
    step(7'b0, 7'b0, P_CWAIT);
    if (hit) wait_state(M_RC | M_FIND, M_RC | M_FIND, M_RC, dc, P_CWAIT, P_HIT, 1, err);
    else     wait_state(M_RC, M_RC | M_FIND, M_RC, dc, P_CWAIT, P_MISS, 2, err);
    if (err) return;
    if (hit) begin
      step(7'b0, 7'b0, P_READ);
      return;
    end
    step(7'b0, 7'b0, P_MWAIT);
    wait_state(M_RM, M_RM, M_RM, dm, P_MWAIT, P_FILL, 0, err);
    if (err) return;
    step(7'b0, 7'b0, P_FWAIT);
    wait_state(M_WR, M_WR, M_WR, dw, P_FWAIT, P_MOUT, 0, err);
    if (err) return;
    step(7'b0, 7'b0, P_READ);
  endtask

  task automatic linger(input logic [10:0] ph);
    repeat ($urandom_range(0, 3)) step(M_START, M_START, ph);
    step(7'b0, M_START, P_IDLE);
    step(7'b0, M_START, P_IDLE);
  endtask

  task automatic end_session();
    step(7'b0, 7'b0, P_CHECK);
    step(M_FIN, M_FIN, P_DONE);
    linger(P_DONE);
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
  endfunction

  task automatic random_session(input int n_addr);
    bit err;
    begin_session();
    for (int a = 0; a < n_addr; a++) begin
      do_addr(1'($urandom_range(0, 1)), rand_delay(), rand_delay(), rand_delay(), err);
      if (err) begin
        linger(P_ERR);
        return;
      end
    end
    end_session();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit err;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ctl", int'(dut_v), 0);
    check("reset_hitCnt", int'(hitCnt), 0);
    check("reset_missCnt", int'(missCnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(7'b0, M_START, P_IDLE);

    // Empty stream: finish seen at the first CHECK
    trace.delete();
    begin_session();
    step(7'b0, 7'b0, P_CHECK);
    step(M_FIN, M_FIN, P_DONE);
    check("empty_done_cycle", first_idx(B_DONE), 3);
    check("empty_readerEn_pulses", count_bit(B_RE), 1);
    check("empty_adrEn_pulses", count_bit(B_ADR), 0);
    check("empty_busy_at_done", int'(trace[2][B_BUSY]), 0);
    linger(P_DONE);

    // Single hit, cache answers on first CWAIT cycle
    trace.delete();
    begin_session();
    do_addr(1'b1, 0, 0, 0, err);
    check("hit_readerEn_cycle", first_idx(B_RE), 1);
    check("hit_adrEn_cycle", first_idx(B_ADR), 3);
    check("hit_startCache_cycle", first_idx(B_SC), 4);
    check("hit_outputEn_cycle", first_idx(B_OE), 6);
    check("hit_MemSel_count", count_bit(B_MS), 0);
    check("hit_hitCnt", int'(hitCnt), STATS);
    end_session();

    // Single miss: readyMem on 4th MWAIT cycle, writed on 3rd FWAIT cycle
    trace.delete();
    begin_session();
    do_addr(1'b0, 0, 3, 2, err);
    check("miss_startMem_cycle", first_idx(B_SM), 6);
    check("miss_startMem_pulses", count_bit(B_SM), 1);
    check("miss_forc_cycles", count_bit(B_FORC), 9);
    check("miss_We_cycles", count_bit(B_WE), 4);
    check("miss_MemSel_cycle", first_idx(B_MS), 15);
    check("miss_outputEn_cycle", first_idx(B_OE), 15);
    check("miss_missCnt", int'(missCnt), STATS);
    end_session();

    // Memory never answers: timeout after WAIT_MAX MWAIT cycles
    trace.delete();
    begin_session();
    do_addr(1'b0, 1, WAIT_MAX, 0, err);
    check("timeout_err_flag", int'(err), 1);
    check("timeout_cycle", first_idx(B_TO), 12);
    check("timeout_mwait_cycles", count_bit(B_FORC) - 1, WAIT_MAX);
    linger(P_ERR);

    // Asynchronous reset in the middle of a fill
    begin_session();
    step(7'b0, 7'b0, P_CHECK);
    step(7'b0, M_FIN, P_ADR);
    step(7'b0, 7'b0, P_LOOKUP);
    step(7'b0, 7'b0, P_CWAIT);
    misses++;
    step(M_RC, M_RC | M_FIND, P_MISS);
    step(7'b0, 7'b0, P_MWAIT);
    step(M_RM, M_RM, P_FILL);
    step(7'b0, M_WR, P_FWAIT);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_ctl", int'(dut_v), 0);
    check("async_reset_missCnt", int'(missCnt), 0);
    @(posedge clk);
    #1;
    check("reset_hold_ctl", int'(dut_v), 0);
    #1 rst_n = 1'b1;
    hits = 0;
    misses = 0;
    step(7'b0, M_START, P_IDLE);
    step(7'b0, M_START, P_IDLE);

    for (int s = 0; s < 40; s++) random_session($urandom_range(1, 6));

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
